// File: rtl/sb_rx_pkg.sv
// -----------------------------------------------------------------------------
// sb_rx_pkg
// Shared types and constants for the sideband receive deframer.
//   bit_state_t       : states of the oversampling UART symbol FSM
//   frame_state_t     : states of the DLE framing FSM
//   DLE_DEFAULT       : frame escape byte
//   ETX_DEFAULT       : end-of-transaction byte following DLE
//   mid_sample_offset : counter value at which the start bit is re-checked
// -----------------------------------------------------------------------------
package sb_rx_pkg;

  typedef enum logic [1:0] {
    B_IDLE  = 2'd0,
    B_START = 2'd1,
    B_DATA  = 2'd2,
    B_STOP  = 2'd3
  } bit_state_t;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_DLE1 = 2'd1,
    F_BODY = 2'd2,
    F_DLE2 = 2'd3
  } frame_state_t;

  localparam logic [7:0] DLE_DEFAULT = 8'hFE;
  localparam logic [7:0] ETX_DEFAULT = 8'h40;

  // Start-bit re-check point, counted from the first cycle after the falling
  // edge is seen; integer division keeps it just before the bit centre.
  function automatic int unsigned mid_sample_offset(input int unsigned os);
    return os / 32'd2;
  endfunction

endpackage

// File: rtl/sb_rx_uart.sv
// -----------------------------------------------------------------------------
// sb_rx_uart
// Oversampling UART receiver for the sideband line: start bit 0, 8 data bits
// LSB first, stop bit 1.
// Ports:
//   sb_clk_i     sideband sampling clock
//   rst_ni       asynchronous active-low reset
//   enable_i     0 holds the bit FSM in B_IDLE
//   sbrx_i       asynchronous serial input, idles high
//   byte_o       received byte, valid with byte_stb_o
//   byte_stb_o   one-cycle strobe: a symbol with a good stop bit arrived
//   sym_err_o    one-cycle pulse: stop bit sampled low
// -----------------------------------------------------------------------------
module sb_rx_uart
  import sb_rx_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 5
) (
  input  logic       sb_clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic       sbrx_i,
  output logic [7:0] byte_o,
  output logic       byte_stb_o,
  output logic       sym_err_o
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 32'd1);
  localparam logic [CW-1:0] CNT_MID  = CW'(mid_sample_offset(OVERSAMPLE));

  logic [1:0]    sync_q;
  logic          s_rx_s;
  bit_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          brk_q, brk_d;
  logic [7:0]    byte_q, byte_d;
  logic          stb_q, stb_d;
  logic          err_q, err_d;

  assign s_rx_s     = sync_q[1];
  assign byte_o     = byte_q;
  assign byte_stb_o = stb_q;
  assign sym_err_o  = err_q;

  // Two-flop synchronizer for the asynchronous line; idles high.
  always_ff @(posedge sb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], sbrx_i};
    end
  end

  // Symbol FSM next-state: start check, 8 data samples, stop check.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    brk_d     = brk_q;
    byte_d    = byte_q;
    stb_d     = 1'b0;
    err_d     = 1'b0;
    if (!enable_i) begin
      state_d   = B_IDLE;
      cnt_d     = '0;
      bit_cnt_d = 3'd0;
      brk_d     = 1'b0;
    end else begin
      case (state_q)
        B_IDLE: begin
          cnt_d = '0;
          if (!s_rx_s) begin
            state_d = B_START;
          end else begin
            state_d = B_IDLE;
          end
        end
        B_START: begin
          if (cnt_q == CNT_MID) begin
            cnt_d     = '0;
            bit_cnt_d = 3'd0;
            // A line back high at mid-start is noise, not a symbol.
            if (s_rx_s) begin
              state_d = B_IDLE;
            end else begin
              state_d = B_DATA;
            end
          end else begin
            state_d = B_START;
          end
        end
        B_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            shift_d = {s_rx_s, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = 3'd0;
              state_d   = B_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            state_d = B_DATA;
          end
        end
        B_STOP: begin
          if (brk_q) begin
            // Bad stop bit seen: hold off until the line returns high so the
            // low tail is not mistaken for a new start bit.
            cnt_d = '0;
            if (s_rx_s) begin
              brk_d   = 1'b0;
              state_d = B_IDLE;
            end else begin
              state_d = B_STOP;
            end
          end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (s_rx_s) begin
              stb_d   = 1'b1;
              byte_d  = shift_q;
              state_d = B_IDLE;
            end else begin
              err_d = 1'b1;
              brk_d = 1'b1;
            end
          end else begin
            state_d = B_STOP;
          end
        end
        default: begin
          state_d = B_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Symbol FSM state and output registers.
  always_ff @(posedge sb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= B_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      brk_q     <= 1'b0;
      byte_q    <= 8'h00;
      stb_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      brk_q     <= brk_d;
      byte_q    <= byte_d;
      stb_q     <= stb_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: rtl/sb_rx_deframer.sv
// -----------------------------------------------------------------------------
// sb_rx_deframer
// Sideband receive front-end: recovers UART symbols from sbrx, strips DLE
// framing and DLE stuffing, and presents a valid/sop/eop byte stream.
// Ports:
//   sb_clk     sideband sampling clock
//   rst        asynchronous active-low reset
//   enable     0 idles both FSMs and holds outputs at reset values
//   sbrx       asynchronous serial input, idles high
//   rx_data    de-stuffed transaction byte
//   rx_valid   one-cycle strobe qualifying rx_data
//   rx_sop     first byte (STX/command) of a transaction
//   rx_eop     last byte of a transaction
//   frame_err  one-cycle pulse: current transaction aborted
// Optional (macro SB_RX_STATS_EN):
//   frames_ok  saturating count of rx_eop
//   frames_err saturating count of frame_err pulses
// -----------------------------------------------------------------------------
module sb_rx_deframer
  import sb_rx_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 5,
  parameter int unsigned MAX_LEN    = 64,
  parameter logic [7:0]  DLE        = DLE_DEFAULT,
  parameter logic [7:0]  ETX        = ETX_DEFAULT
) (
  input  logic        sb_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        sbrx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sop,
  output logic        rx_eop,
  output logic        frame_err
`ifdef SB_RX_STATS_EN
  ,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_err
`endif
);

  localparam int unsigned LW = $clog2(MAX_LEN + 32'd1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

  logic [7:0]   byte_s;
  logic         byte_stb_s;
  logic         sym_err_s;

  frame_state_t fstate_q, fstate_d;
  logic [7:0]   hold_q, hold_d;
  logic         first_q, first_d;
  logic [LW-1:0] len_q, len_d;
  logic         ovf_q, ovf_d;
  logic         emit_s, emit_eop_s, err_s;

  logic [7:0]   rx_data_q, rx_data_d;
  logic         rx_valid_q, rx_sop_q, rx_eop_q, frame_err_q;

  sb_rx_uart #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_uart (
    .sb_clk_i  (sb_clk),
    .rst_ni    (rst),
    .enable_i  (enable),
    .sbrx_i    (sbrx),
    .byte_o    (byte_s),
    .byte_stb_o(byte_stb_s),
    .sym_err_o (sym_err_s)
  );

  // Frame FSM next-state, hold register and emission decode.
  always_comb begin
    fstate_d   = fstate_q;
    hold_d     = hold_q;
    first_d    = first_q;
    len_d      = len_q;
    ovf_d      = 1'b0;
    emit_s     = 1'b0;
    emit_eop_s = 1'b0;
    // A length overflow emits the held byte first; its error pulse follows a
    // cycle later so frame_err never coincides with rx_valid.
    err_s      = ovf_q;
    if (!enable) begin
      fstate_d = F_IDLE;
      first_d  = 1'b0;
      len_d    = '0;
      err_s    = 1'b0;
    end else if (sym_err_s) begin
      fstate_d = F_IDLE;
      err_s    = 1'b1;
    end else if (byte_stb_s) begin
      case (fstate_q)
        F_IDLE: begin
          if (byte_s == DLE) begin
            fstate_d = F_DLE1;
          end else begin
            fstate_d = F_IDLE;
          end
        end
        F_DLE1: begin
          if ((byte_s == DLE) || (byte_s == ETX)) begin
            fstate_d = F_IDLE;
          end else begin
            hold_d   = byte_s;
            first_d  = 1'b1;
            len_d    = LW'(1);
            fstate_d = F_BODY;
          end
        end
        F_BODY: begin
          if (byte_s == DLE) begin
            fstate_d = F_DLE2;
          end else begin
            emit_s = 1'b1;
            if (len_q == LEN_MAX) begin
              ovf_d    = 1'b1;
              fstate_d = F_IDLE;
            end else begin
              hold_d  = byte_s;
              first_d = 1'b0;
              len_d   = len_q + LW'(1);
            end
          end
        end
        F_DLE2: begin
          if (byte_s == DLE) begin
            // Stuffed DLE: the data byte is DLE itself.
            emit_s = 1'b1;
            if (len_q == LEN_MAX) begin
              ovf_d    = 1'b1;
              fstate_d = F_IDLE;
            end else begin
              hold_d   = DLE;
              first_d  = 1'b0;
              len_d    = len_q + LW'(1);
              fstate_d = F_BODY;
            end
          end else if (byte_s == ETX) begin
            emit_s     = 1'b1;
            emit_eop_s = 1'b1;
            fstate_d   = F_IDLE;
          end else begin
            err_s    = 1'b1;
            fstate_d = F_IDLE;
          end
        end
        default: begin
          fstate_d = F_IDLE;
        end
      endcase
    end else begin
      fstate_d = fstate_q;
    end
  end

  // Output data next-value: hold the last byte, clear while disabled.
  always_comb begin
    rx_data_d = rx_data_q;
    if (!enable) begin
      rx_data_d = 8'h00;
    end else if (emit_s) begin
      rx_data_d = hold_q;
    end else begin
      rx_data_d = rx_data_q;
    end
  end

  // Frame FSM state and registered outputs.
  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      fstate_q    <= F_IDLE;
      hold_q      <= 8'h00;
      first_q     <= 1'b0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_sop_q    <= 1'b0;
      rx_eop_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      fstate_q    <= fstate_d;
      hold_q      <= hold_d;
      first_q     <= first_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= emit_s;
      rx_sop_q    <= emit_s & first_q;
      rx_eop_q    <= emit_eop_s;
      frame_err_q <= err_s;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_sop    = rx_sop_q;
  assign rx_eop    = rx_eop_q;
  assign frame_err = frame_err_q;

`ifdef SB_RX_STATS_EN
  logic [15:0] frames_ok_q;
  logic [15:0] frames_err_q;

  // Saturating good-frame and error counters.
  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      frames_ok_q  <= 16'h0000;
      frames_err_q <= 16'h0000;
    end else begin
      if (rx_eop_q && (frames_ok_q != 16'hFFFF)) begin
        frames_ok_q <= frames_ok_q + 16'd1;
      end else begin
        frames_ok_q <= frames_ok_q;
      end
      if (frame_err_q && (frames_err_q != 16'hFFFF)) begin
        frames_err_q <= frames_err_q + 16'd1;
      end else begin
        frames_err_q <= frames_err_q;
      end
    end
  end

  assign frames_ok  = frames_ok_q;
  assign frames_err = frames_err_q;
`endif

endmodule
